// File: rtl/vga_pkg.sv
// ============================================================================
// Module   : vga_pkg
// Brief    : Shared VGA timing constants, test-bar colours and pixel helpers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  localparam int HA      = 144;
  localparam int VA      = 35;

  localparam logic [11:0] C_WHITE   = 12'hFFF;
  localparam logic [11:0] C_YELLOW  = 12'hFF0;
  localparam logic [11:0] C_CYAN    = 12'h0FF;
  localparam logic [11:0] C_GREEN   = 12'h0F0;
  localparam logic [11:0] C_MAGENTA = 12'hF0F;
  localparam logic [11:0] C_RED     = 12'hF00;
  localparam logic [11:0] C_BLUE    = 12'h00F;
  localparam logic [11:0] C_BLACK   = 12'h000;

  function automatic logic [11:0] rgb888_to_444(input logic [23:0] c);
    return {c[23:20], c[15:12], c[7:4]};
  endfunction

  // Eight 80-pixel bars left to right; a compare chain avoids a divider.
  function automatic logic [11:0] test_bar(input logic [9:0] col);
    logic [11:0] c;
    if      (col < 10'd80)  c = C_WHITE;
    else if (col < 10'd160) c = C_YELLOW;
    else if (col < 10'd240) c = C_CYAN;
    else if (col < 10'd320) c = C_GREEN;
    else if (col < 10'd400) c = C_MAGENTA;
    else if (col < 10'd480) c = C_RED;
    else if (col < 10'd560) c = C_BLUE;
    else                    c = C_BLACK;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_ctrl_if.sv
// ============================================================================
// Module   : vga_timing_ctrl_if
// Brief    : Pixel-lookup request/response and board-pin bundle of the VGA driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface vga_timing_ctrl_if;
  logic [23:0] pos_data;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        pix_req;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_de;
  logic [11:0] vga_rgb;
  logic        frame_start;

  modport master (
    input  pos_data,
    output pos_x, pos_y, pix_req,
    output vga_hs, vga_vs, vga_de, vga_rgb, frame_start
  );

  modport slave (
    output pos_data,
    input  pos_x, pos_y, pix_req,
    input  vga_hs, vga_vs, vga_de, vga_rgb, frame_start
  );
endinterface

`default_nettype wire

// File: rtl/vga_scan_counter.sv
// ============================================================================
// Module   : vga_scan_counter
// Brief    : Horizontal/vertical raster counters with sync and active-row decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_scan_counter #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  output logic [9:0] hcnt_o,
  output logic [9:0] vcnt_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       row_active_o,
  output logic       frame_wrap_o
);

  localparam logic [9:0] C_H_LAST  = 10'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
  localparam logic [9:0] C_V_LAST  = 10'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
  localparam logic [9:0] C_H_SYNC  = 10'(H_SYNC);
  localparam logic [9:0] C_V_SYNC  = 10'(V_SYNC);
  localparam logic [9:0] C_VA      = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] C_VA_END  = 10'(V_SYNC + V_BACK + V_ACTIVE);

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       h_wrap;
  logic       v_last;

  always_comb begin
    h_wrap = (hcnt_q == C_H_LAST);
    v_last = (vcnt_q == C_V_LAST);
    hcnt_d = h_wrap ? 10'd0 : hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (h_wrap) begin
      vcnt_d = v_last ? 10'd0 : vcnt_q + 10'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt_o       = hcnt_q;
  assign vcnt_o       = vcnt_q;
  assign hsync_o      = (hcnt_q < C_H_SYNC);
  assign vsync_o      = (vcnt_q < C_V_SYNC);
  assign row_active_o = (vcnt_q >= C_VA) && (vcnt_q < C_VA_END);
  assign frame_wrap_o = h_wrap && v_last;

endmodule

`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
// ============================================================================
// Module   : vga_timing_ctrl
// Brief    : 640x480 raster driver issuing look-ahead pixel requests and
//            aligning returned RGB with sync/DE. VGA_TEST_PATTERN_EN selects
//            built-in colour bars instead of pos_data.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int DATA_LAT = 1
) (
  input  logic               vga_clk,
  input  logic               rst_n,
  vga_timing_ctrl_if.master  bus
);

  localparam logic [9:0] C_VA        = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] C_REQ_START = 10'(H_SYNC + H_BACK - DATA_LAT - 1);
  localparam logic [9:0] C_REQ_END   = 10'(H_SYNC + H_BACK + H_ACTIVE - DATA_LAT - 1);

  logic [9:0]  hcnt, vcnt;
  logic        hsync, vsync, row_active, frame_wrap;
  logic        req;
  logic [9:0]  pos_x_w;
  logic [11:0] pix_rgb;

  logic [DATA_LAT:0] hs_pipe_q;
  logic [DATA_LAT:0] vs_pipe_q;
  logic [DATA_LAT:0] de_pipe_q;
  logic [11:0]       rgb_q;
  logic              frame_start_q;

  vga_scan_counter #(
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT)
  ) u_scan (
    .vga_clk      (vga_clk),
    .rst_n        (rst_n),
    .hcnt_o       (hcnt),
    .vcnt_o       (vcnt),
    .hsync_o      (hsync),
    .vsync_o      (vsync),
    .row_active_o (row_active),
    .frame_wrap_o (frame_wrap)
  );

  // Requests lead the active region by DATA_LAT+1 so the pixel lands on the pins exactly at HA.
  assign req     = row_active && (hcnt >= C_REQ_START) && (hcnt < C_REQ_END);
  assign pos_x_w = req ? (hcnt - C_REQ_START) : 10'd0;

  assign bus.pix_req = req;
  assign bus.pos_x   = pos_x_w;
  assign bus.pos_y   = req ? (vcnt - C_VA) : 10'd0;

`ifdef VGA_TEST_PATTERN_EN
  logic [DATA_LAT-1:0][9:0] col_pipe_q;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      col_pipe_q <= '0;
    end else begin
      col_pipe_q[0] <= pos_x_w;
      for (int i = 1; i < DATA_LAT; i++) begin
        col_pipe_q[i] <= col_pipe_q[i-1];
      end
    end
  end

  assign pix_rgb = test_bar(col_pipe_q[DATA_LAT-1]);
`else
  assign pix_rgb = rgb888_to_444(bus.pos_data);
`endif

  // de_pipe_q[DATA_LAT-1] marks the cycle in which pos_data answers a valid request.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
      de_pipe_q     <= '0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hs_pipe_q     <= {hs_pipe_q[DATA_LAT-1:0], ~hsync};
      vs_pipe_q     <= {vs_pipe_q[DATA_LAT-1:0], ~vsync};
      de_pipe_q     <= {de_pipe_q[DATA_LAT-1:0], req};
      rgb_q         <= de_pipe_q[DATA_LAT-1] ? pix_rgb : 12'h000;
      frame_start_q <= frame_wrap;
    end
  end

  assign bus.vga_hs      = hs_pipe_q[DATA_LAT];
  assign bus.vga_vs      = vs_pipe_q[DATA_LAT];
  assign bus.vga_de      = de_pipe_q[DATA_LAT];
  assign bus.vga_rgb     = rgb_q;
  assign bus.frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
// ============================================================================
// Module   : tb_vga_timing_ctrl
// Brief    : Directed self-checking bench for vga_timing_ctrl on a shrunken raster.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing_ctrl;

  localparam int HS = 4, HB = 6, HACT = 16, HF = 4;
  localparam int VS = 2, VB = 3, VACT = 4, VF = 1;
  localparam int LAT   = 1;
  localparam int HT    = HS + HB + HACT + HF;   // 30
  localparam int VT    = VS + VB + VACT + VF;   // 10
  localparam int FRAME = HT * VT;               // 300
  localparam int HA    = HS + HB;               // 10
  localparam int VA    = VS + VB;               // 5

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int total = 0;
  int bad   = 0;
  int kk    = 0;

  int n_req, n_fs, first_fs, n_vs_low, fall1, fall2, rise1;
  logic prev_hs;

  vga_timing_ctrl_if bus ();

  vga_timing_ctrl #(
    .H_SYNC (HS), .H_BACK (HB), .H_ACTIVE (HACT), .H_FRONT (HF),
    .V_SYNC (VS), .V_BACK (VB), .V_ACTIVE (VACT), .V_FRONT (VF),
    .DATA_LAT (LAT)
  ) dut (
    .vga_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (k=%0d)", tag, act, exp, kk);
    end
  endtask

  function automatic logic [11:0] bar_of(input int x);
    case (x / 80)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  // Lookup ROM with one-cycle latency; frame 1 returns a fixed colour.
  initial begin : rom
    logic [9:0] xq, yq;
    bit ov;
    bus.pos_data = 24'h0;
    forever begin
      @(negedge clk);
      xq = bus.pos_x;
      yq = bus.pos_y;
      ov = (kk / FRAME == 1);
      @(posedge clk);
      #1;
      bus.pos_data = ov ? 24'hFF8040 : {xq[3:0], 4'h9, yq[3:0], 4'h6, 8'h5A};
    end
  end

  task automatic clear_stats();
    n_req = 0; n_fs = 0; first_fs = -1; n_vs_low = 0;
    fall1 = -1; fall2 = -1; rise1 = -1; prev_hs = 1'b1;
  endtask

  task automatic run_span(input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      int hc, vc, d, e_hs, e_vs, e_de, e_req, e_px, e_py, e_fs;
      logic [11:0] e_rgb;
      logic [9:0]  xv, yv;
      @(posedge clk);
      #1;
      kk = k;
      hc = k % HT;
      vc = (k / HT) % VT;
      d  = k - (LAT + 1);
      e_hs  = (d < 0) ? 1 : (((d % HT) < HS) ? 0 : 1);
      e_vs  = (d < 0) ? 1 : ((((d / HT) % VT) < VS) ? 0 : 1);
      e_de  = (hc >= HA && hc < HA + HACT && vc >= VA && vc < VA + VACT) ? 1 : 0;
      e_req = (vc >= VA && vc < VA + VACT &&
               hc >= HA - LAT - 1 && hc < HA + HACT - LAT - 1) ? 1 : 0;
      e_px  = e_req ? hc - (HA - LAT - 1) : 0;
      e_py  = e_req ? vc - VA : 0;
      e_fs  = (k > 0 && hc == 0 && vc == 0) ? 1 : 0;
      xv = 10'(hc - HA);
      yv = 10'(vc - VA);
`ifdef VGA_TEST_PATTERN_EN
      e_rgb = e_de ? bar_of(hc - HA) : 12'h000;
`else
      e_rgb = !e_de ? 12'h000 : ((k / FRAME == 1) ? 12'hF84 : {xv[3:0], yv[3:0], 4'h5});
`endif
      chk_eq("hs",      32'(bus.vga_hs),      32'(e_hs));
      chk_eq("vs",      32'(bus.vga_vs),      32'(e_vs));
      chk_eq("de",      32'(bus.vga_de),      32'(e_de));
      chk_eq("rgb",     32'(bus.vga_rgb),     32'(e_rgb));
      chk_eq("pix_req", 32'(bus.pix_req),     32'(e_req));
      chk_eq("pos_x",   32'(bus.pos_x),       32'(e_px));
      chk_eq("pos_y",   32'(bus.pos_y),       32'(e_py));
      chk_eq("fs",      32'(bus.frame_start), 32'(e_fs));
      if (k <= 2 * FRAME) begin
        if (bus.pix_req) n_req++;
        if (bus.frame_start) begin
          n_fs++;
          if (first_fs < 0) first_fs = k;
        end
        if (!bus.vga_vs) n_vs_low++;
        if (prev_hs && !bus.vga_hs) begin
          if (fall1 < 0) fall1 = k;
          else if (fall2 < 0) fall2 = k;
        end
        if (!prev_hs && bus.vga_hs && rise1 < 0) rise1 = k;
        prev_hs = bus.vga_hs;
      end
    end
  endtask

  task automatic chk_reset_state(input string pfx);
    chk_eq({pfx, "_hs"},  32'(bus.vga_hs),      32'd1);
    chk_eq({pfx, "_vs"},  32'(bus.vga_vs),      32'd1);
    chk_eq({pfx, "_de"},  32'(bus.vga_de),      32'd0);
    chk_eq({pfx, "_rgb"}, 32'(bus.vga_rgb),     32'd0);
    chk_eq({pfx, "_fs"},  32'(bus.frame_start), 32'd0);
    chk_eq({pfx, "_req"}, 32'(bus.pix_req),     32'd0);
    chk_eq({pfx, "_px"},  32'(bus.pos_x),       32'd0);
    chk_eq({pfx, "_py"},  32'(bus.pos_y),       32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("rst");

    @(negedge clk);
    rst_n = 1'b1;
    kk = 0;
    clear_stats();
    // Two full frames, then stop mid-line at hcnt=15, vcnt=6 of frame 2.
    run_span(1, 2 * FRAME + 6 * HT + 15);
    chk_eq("hs_first_fall", 32'(fall1),          32'(LAT + 1));
    chk_eq("hs_low_width",  32'(rise1 - fall1),  32'(HS));
    chk_eq("hs_period",     32'(fall2 - fall1),  32'(HT));
    chk_eq("vs_low_cycles", 32'(n_vs_low),       32'(2 * VS * HT));
    chk_eq("req_count",     32'(n_req),          32'(2 * VACT * HACT));
    chk_eq("fs_count",      32'(n_fs),           32'd2);
    chk_eq("fs_first",      32'(first_fs),       32'(FRAME));

    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_rst");

    @(negedge clk);
    rst_n = 1'b1;
    kk = 0;
    clear_stats();
    run_span(1, FRAME + 1);
    chk_eq("re_hs_first_fall", 32'(fall1),    32'(LAT + 1));
    chk_eq("re_fs_count",      32'(n_fs),     32'd1);
    chk_eq("re_fs_first",      32'(first_fs), 32'(FRAME));
    chk_eq("re_req_count",     32'(n_req),    32'(VACT * HACT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
